// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product input stream and frame-sum result handshake
interface mac_accumulator_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
);
    logic [PROD_W-1:0] prod_in;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              clear;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic              out_ready;
    logic              sat;
    logic [CNT_W-1:0]  beat_cnt;

    modport master (
        output prod_in, in_valid, in_last, clear, out_ready,
        input  in_ready, acc_out, out_valid, sat, beat_cnt
    );

    modport slave (
        input  prod_in, in_valid, in_last, clear, out_ready,
        output in_ready, acc_out, out_valid, sat, beat_cnt
    );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating frame accumulator of signed products with result handshake
module mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              rst_n,
    mac_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W:0]   sum;
    logic             ovf;

    assign bus.in_ready  = (state_q != DONE) && !bus.clear;
    assign bus.out_valid = state_q == DONE;
    assign bus.acc_out   = acc_q;
    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.sat       = sat_q;

    // next state: one guard bit catches overflow, clamp to the signed rail it crossed
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        sat_d      = sat_q;
        sum        = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){bus.prod_in[PROD_W-1]}}, bus.prod_in};
        ovf        = sum[ACC_W] ^ sum[ACC_W-1];
        if (state_q == DONE) begin
            if (bus.out_ready) begin
                state_d    = IDLE;
                acc_d      = '0;
                beat_cnt_d = '0;
                sat_d      = 1'b0;
            end
        end else if (bus.clear) begin
            state_d    = IDLE;
            acc_d      = '0;
            beat_cnt_d = '0;
            sat_d      = 1'b0;
        end else if (bus.in_valid) begin
            acc_d      = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
            sat_d      = sat_q | ovf;
            beat_cnt_d = &beat_cnt_q ? beat_cnt_q : beat_cnt_q + 1'b1;
            state_d    = bus.in_last ? DONE : ACCUM;
        end
    end

    // state and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            sat_q      <= sat_d;
        end
    end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Downstream consumer of the 16x16 signed multiplier's 32-bit product stream. It accumulates a frame of signed products into a wide saturating accumulator and presents the frame sum with a valid/ready handshake. Typical use is dot-product or FIR tap summation behind the multiplier. Frames are delimited by in_last; a synchronous clear aborts a frame in progress.

Parameters:
PROD_W, 32, width of signed product input
ACC_W, 40, width of signed accumulator/result (must be > PROD_W)
CNT_W, 8, width of beat counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
prod_in  in  PROD_W  signed product from multiplier
in_valid  in  1  prod_in valid
in_last  in  1  marks final product of frame, qualified by in_valid
in_ready  out  1  block can accept a product this cycle
clear  in  1  synchronous frame abort
acc_out  out  ACC_W  signed frame sum, stable while out_valid
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
sat  out  1  sticky: saturation occurred in this frame, valid with out_valid
beat_cnt  out  CNT_W  products accepted in frame, including last

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; accumulator, acc_out, beat_cnt = 0; out_valid = 0; sat = 0. Reset mid-frame discards all partial state.
- States: IDLE (no beats accepted), ACCUM (>=1 beat accepted, no last yet), DONE (result held).
- in_ready = (state != DONE) && !clear. Combinational from state and clear only, never from in_valid.
- Accept = in_valid && in_ready. On accept: acc <= sat_add(acc, sign-extend(prod_in)); beat_cnt <= beat_cnt+1, saturating at 2^CNT_W-1 (no wrap).
- sat_add: compute in ACC_W+1 bits. If above 2^(ACC_W-1)-1, clamp to that value; if below -2^(ACC_W-1), clamp to that value. Either clamp sets sat (sticky until frame end). Once clamped, later beats continue from the clamped value, so an opposite-sign product can pull the sum back in range. sat stays set.
- Transitions:
  - IDLE/ACCUM, accept, !in_last -> ACCUM.
  - IDLE/ACCUM, accept, in_last -> DONE. out_valid=1 from the next cycle, so latency is 1 cycle from last-beat accept. acc_out, sat and beat_cnt reflect the last beat included.
  - A single-beat frame (in_last on first beat) is legal: IDLE -> DONE.
  - DONE, out_ready -> IDLE on the next edge. out_valid drops. Accumulator, beat_cnt and sat are cleared. in_ready rises the same cycle out_valid drops, with no bubble beyond that one cycle.
  - DONE, !out_ready -> hold. acc_out, sat and beat_cnt stay stable.
- clear in IDLE/ACCUM: next edge acc=0, beat_cnt=0, sat=0, state IDLE. in_ready is low that cycle, so no beat is accepted.
- clear in DONE: ignored; the result is not lost.
- in_last with in_valid low has no effect.
- acc_out is a registered output. Between frames (IDLE/ACCUM) it shows the running accumulator value. It is meaningful only when out_valid=1.

Test Plan:
- Reset then frame of 4 products 100, -30, 7, 1000 (last on 4th), out_ready=1 -> out_valid one cycle after 4th accept, acc_out=1077, beat_cnt=4, sat=0. out_valid is high for exactly 1 cycle, then state IDLE with acc=0.
- Single-beat frame: prod_in=-1073741824 with in_last -> acc_out=-1073741824, beat_cnt=1, one-cycle latency.
- Saturation with ACC_W=34: 8 beats of 1073741824 (last on 8th) -> acc_out=8589934591 and sat=1. Then 1 more beat of -1073741824 on a 9-beat frame -> acc_out=7516192767 and sat=1.
- Backpressure: out_ready held low 5 cycles after result (sum=42) -> out_valid and acc_out=42 stable, in_ready=0, clear asserted during hold is ignored. out_ready=1 releases, then the next frame starts clean.
- clear mid-frame: accept 50, 60, assert clear with in_valid=1, prod_in=999 -> 999 not accepted, acc=0, beat_cnt=0. Next frame 5 (last) -> acc_out=5.
- Async reset mid-frame after beats 10, 20: rst_n low between edges -> outputs immediately 0. After release, frame 3 (last) -> acc_out=3, beat_cnt=1.
